sdram_cpu_bridge: RTL and testbench

//  CPU-side front end for the 64 MB SDRAM/VGA memory block. Accepts byte or 16-bit word

---
 rtl/sdram_cpu_bridge_if.sv | 31 +++
 rtl/sdram_cpu_bridge.sv | 157 +++++++++++++++
 tb/tb_sdram_cpu_bridge.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cpu_bridge_if.sv
// Signal bundle between the CPU bus, the bridge and the SDRAM/VGA memory block.
// The bridge connects through the master modport. The CPU and memory side connect through the slave modport.
interface sdram_cpu_bridge_if;
  // Handshake: cpu_req is a one-cycle start strobe, taken only while cpu_busy=0, and each
  // accepted request ends with exactly one cpu_done pulse. On the memory side a transaction
  // starts when m_address changes, and it completes only when m_ready is seen low and then high.
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_word;
  logic [25:0] cpu_address;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic        cpu_done;
  logic        cpu_err;
  logic [25:0] m_address;
  logic        m_we;
  logic [7:0]  m_wdata;
  logic [7:0]  m_rdata;
  logic        m_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_word, cpu_address, cpu_wdata, m_rdata, m_ready,
    output cpu_rdata, cpu_busy, cpu_done, cpu_err, m_address, m_we, m_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_word, cpu_address, cpu_wdata, m_rdata, m_ready,
    input  cpu_rdata, cpu_busy, cpu_done, cpu_err, m_address, m_we, m_wdata
  );
endinterface

// File: rtl/sdram_cpu_bridge.sv
// CPU front end for the SDRAM/VGA memory block: byte/word requests become byte
// transactions on the memory's address-change / ready interface.
module sdram_cpu_bridge #(
  parameter int TIMEOUT = 4096
) (
  input  logic                      clock_100_mhz,
  input  logic                      reset_n,
  sdram_cpu_bridge_if.master        bus,
  output logic [2:0]                dbg_state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    DUMMY_LO = 3'd2,
    DUMMY_HI = 3'd3,
    WAIT_LO  = 3'd4,
    WAIT_HI  = 3'd5,
    DONE     = 3'd6
  } state_t;

  localparam int CW = $clog2(TIMEOUT);

  state_t        state, state_n;
  logic [CW-1:0] tmo_cnt;
  logic          lat_we, lat_word, idx;
  logic [25:0]   lat_addr, target;
  logic [15:0]   lat_wdata, rdata_q;
  logic          busy_q, done_q, err_q, m_we_q;
  logic [25:0]   m_address_q;
  logic [7:0]    m_wdata_q;
  logic          accept, drive_real, drive_dummy, capture, advance, timed_out;
  logic          tmo_hit, waiting;

  assign target        = lat_addr + {25'd0, idx};
  assign tmo_hit       = (tmo_cnt == CW'(TIMEOUT - 1));
  assign waiting       = (state == DUMMY_LO) || (state == DUMMY_HI) ||
                         (state == WAIT_LO)  || (state == WAIT_HI);
  assign dbg_state     = state;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_busy  = busy_q;
  assign bus.cpu_done  = done_q;
  assign bus.cpu_err   = err_q;
  assign bus.m_address = m_address_q;
  assign bus.m_we      = m_we_q;
  assign bus.m_wdata   = m_wdata_q;

  always_ff @(posedge clock_100_mhz or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Each wait state moves on only on the m_ready edge it is waiting for.
  // A real ready event wins over a timeout that expires in the same cycle.
  always_comb begin
    state_n     = state;
    accept      = 1'b0;
    drive_real  = 1'b0;
    drive_dummy = 1'b0;
    capture     = 1'b0;
    advance     = 1'b0;
    timed_out   = 1'b0;
    case (state)
      IDLE: if (bus.cpu_req) begin
        accept  = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: begin
        // An unchanged address would not start a memory cycle, so touch the neighbour first.
        if (target == m_address_q) begin
          drive_dummy = 1'b1;
          state_n     = DUMMY_LO;
        end else begin
          drive_real = 1'b1;
          state_n    = WAIT_LO;
        end
      end
      DUMMY_LO: begin
        if (!bus.m_ready)  state_n = DUMMY_HI;
        else if (tmo_hit) begin timed_out = 1'b1; state_n = DONE; end
      end
      DUMMY_HI: begin
        if (bus.m_ready) begin
          drive_real = 1'b1;
          state_n    = WAIT_LO;
        end else if (tmo_hit) begin timed_out = 1'b1; state_n = DONE; end
      end
      WAIT_LO: begin
        if (!bus.m_ready)  state_n = WAIT_HI;
        else if (tmo_hit) begin timed_out = 1'b1; state_n = DONE; end
      end
      WAIT_HI: begin
        if (bus.m_ready) begin
          capture = !lat_we;
          if (lat_word && !idx) begin
            advance = 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = DONE;
          end
        end else if (tmo_hit) begin timed_out = 1'b1; state_n = DONE; end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_100_mhz or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt     <= '0;
      lat_we      <= 1'b0;
      lat_word    <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      idx         <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      m_address_q <= '0;
      m_we_q      <= 1'b0;
      m_wdata_q   <= '0;
    end else begin
      if (state_n != state) tmo_cnt <= '0;
      else if (waiting)     tmo_cnt <= tmo_cnt + 1'b1;
      if (accept) begin
        lat_we    <= bus.cpu_we;
        lat_word  <= bus.cpu_word;
        lat_addr  <= bus.cpu_address;
        lat_wdata <= bus.cpu_wdata;
        idx       <= 1'b0;
        rdata_q   <= '0;
        busy_q    <= 1'b1;
        err_q     <= 1'b0;
      end
      if (drive_dummy) begin
        m_address_q <= target ^ 26'd1;
        m_we_q      <= 1'b0;
      end
      if (drive_real) begin
        m_address_q <= target;
        m_we_q      <= lat_we;
        m_wdata_q   <= idx ? lat_wdata[15:8] : lat_wdata[7:0];
      end
      if (capture) begin
        if (idx) rdata_q[15:8] <= bus.m_rdata;
        else     rdata_q[7:0]  <= bus.m_rdata;
      end
      if (advance)   idx   <= 1'b1;
      if (timed_out) err_q <= 1'b1;
      done_q <= (state_n == DONE);
      if (state == DONE) begin
        busy_q <= 1'b0;
        m_we_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sdram_cpu_bridge.sv
// Directed bench for sdram_cpu_bridge: CPU driver task, cycle-level memory model with
// programmable ready timing, and a transaction scoreboard on the memory side.
module tb_sdram_cpu_bridge;
  localparam int         TIMEOUT    = 16;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_HI = 3'd5;

  logic       clock_100_mhz = 1'b0;
  logic       reset_n       = 1'b0;
  logic [2:0] dbg_state;

  sdram_cpu_bridge_if bus();

  sdram_cpu_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clock_100_mhz (clock_100_mhz),
    .reset_n       (reset_n),
    .bus           (bus),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_100_mhz = ~clock_100_mhz;

  int cyc = 0;
  always @(posedge clock_100_mhz) cyc++;

  int vectors     = 0;
  int miscompares = 0;

  // Memory transaction record: {we, address, write byte (0 for reads)}
  logic [34:0] exp_q[$];
  logic [34:0] act_q[$];
  logic [34:0] e_txn, g_txn;
  logic [7:0]  mem [logic [25:0]];

  int   lo_delay = 0;
  int   hi_delay = 1;
  bit   stuck    = 0;
  int   rise_cyc = 0;
  int   det_cyc  = 0;

  int          m_phase = 0;
  int          m_cnt   = 0;
  logic [25:0] m_prev  = '0;
  logic [25:0] cur_a   = '0;
  logic        cur_we  = 1'b0;
  logic [7:0]  cur_d   = '0;

  // ---------------- memory model ----------------
  initial begin
    bus.m_ready = 1'b1;
    bus.m_rdata = 8'h00;
    forever begin
      @(negedge clock_100_mhz);
      if (!reset_n) begin
        m_prev      = '0;
        m_phase     = 0;
        bus.m_ready = 1'b1;
      end else begin
        case (m_phase)
          0: if (bus.m_address !== m_prev) begin
            m_prev  = bus.m_address;
            cur_a   = bus.m_address;
            cur_we  = bus.m_we;
            cur_d   = bus.m_we ? bus.m_wdata : 8'h00;
            det_cyc = cyc;
            act_q.push_back({cur_we, cur_a, cur_d});
            if (!stuck) begin
              if (lo_delay == 0) begin
                bus.m_ready = 1'b0;
                m_cnt       = hi_delay;
                m_phase     = 2;
              end else begin
                m_cnt   = lo_delay;
                m_phase = 1;
              end
            end
          end
          1: begin
            m_cnt--;
            if (m_cnt == 0) begin
              bus.m_ready = 1'b0;
              m_cnt       = hi_delay;
              m_phase     = 2;
            end
          end
          2: begin
            m_cnt--;
            if (m_cnt == 0) begin
              if (cur_we) mem[cur_a] = cur_d;
              bus.m_rdata = mem.exists(cur_a) ? mem[cur_a] : 8'h00;
              bus.m_ready = 1'b1;
              rise_cyc    = cyc;
              m_phase     = 0;
            end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  // ---------------- driver ----------------
  logic [15:0] rd;
  logic        er;
  int          rq, dn;

  task automatic cpu_op(input logic we, input logic word, input logic [25:0] a,
                        input logic [15:0] wd, output logic [15:0] rdat,
                        output logic err, output int req_cyc, output int done_cyc);
    bit seen;
    seen = 0;
    @(negedge clock_100_mhz);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_word    = word;
    bus.cpu_address = a;
    bus.cpu_wdata   = wd;
    req_cyc         = cyc;
    @(negedge clock_100_mhz);
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_word    = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_wdata   = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.cpu_done === 1'b1) seen = 1;
      else @(negedge clock_100_mhz);
    end
    rdat     = bus.cpu_rdata;
    err      = bus.cpu_err;
    done_cyc = cyc;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL op_done got no cpu_done want cpu_done within 100 cycles (addr %h)", a);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3;
    vectors++; if (bus.cpu_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.cpu_busy); end
    vectors++; if (bus.cpu_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.cpu_done); end
    vectors++; if (bus.cpu_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.cpu_err); end
    vectors++; if (bus.cpu_rdata !== 16'h0000) begin miscompares++; $display("FAIL reset_rdata got %h want 0000", bus.cpu_rdata); end
    vectors++; if (bus.m_address !== 26'h0) begin miscompares++; $display("FAIL reset_maddr got %h want 0", bus.m_address); end
    vectors++; if (bus.m_we !== 1'b0) begin miscompares++; $display("FAIL reset_mwe got %b want 0", bus.m_we); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
    repeat (3) @(negedge clock_100_mhz);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_byte_write();
    act_q.delete(); exp_q.delete();
    lo_delay = 1; hi_delay = 6;
    cpu_op(1'b1, 1'b0, 26'h100, 16'h005A, rd, er, rq, dn);
    vectors++; if (dn - rq != 10) begin miscompares++; $display("FAIL bw_latency got %0d want 10", dn - rq); end
    vectors++; if (dn != rise_cyc + 1) begin miscompares++; $display("FAIL bw_done_after_ready got %0d want %0d", dn, rise_cyc + 1); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL bw_err got %b want 0", er); end
    vectors++; if (mem[26'h100] !== 8'h5A) begin miscompares++; $display("FAIL bw_mem got %h want 5a", mem[26'h100]); end
    @(negedge clock_100_mhz);
    vectors++; if (bus.cpu_busy !== 1'b0) begin miscompares++; $display("FAIL bw_busy_after got %b want 0", bus.cpu_busy); end
    vectors++; if (bus.m_address !== 26'h100) begin miscompares++; $display("FAIL bw_addr_kept got %h want 100", bus.m_address); end
    exp_q.push_back({1'b1, 26'h100, 8'h5A});
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bw_txn_count got %0d want %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_txn = exp_q.pop_front(); g_txn = act_q.pop_front(); vectors++;
      if (g_txn !== e_txn) begin miscompares++; $display("FAIL bw_txn got %h want %h", g_txn, e_txn); end
    end
  endtask

  task automatic test_word_read();
    act_q.delete(); exp_q.delete();
    lo_delay = 1; hi_delay = 2;
    mem[26'h200] = 8'h34;
    mem[26'h201] = 8'h12;
    cpu_op(1'b0, 1'b1, 26'h200, 16'h0000, rd, er, rq, dn);
    vectors++; if (rd !== 16'h1234) begin miscompares++; $display("FAIL wr_rdata got %h want 1234", rd); end
    @(negedge clock_100_mhz);
    vectors++; if (bus.cpu_done !== 1'b0) begin miscompares++; $display("FAIL wr_single_done got %b want 0", bus.cpu_done); end
    exp_q.push_back({1'b0, 26'h200, 8'h00});
    exp_q.push_back({1'b0, 26'h201, 8'h00});
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wr_txn_count got %0d want %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_txn = exp_q.pop_front(); g_txn = act_q.pop_front(); vectors++;
      if (g_txn !== e_txn) begin miscompares++; $display("FAIL wr_txn got %h want %h", g_txn, e_txn); end
    end
  endtask

  task automatic test_min_latency();
    act_q.delete(); exp_q.delete();
    lo_delay = 0; hi_delay = 1;
    mem[26'h180] = 8'h77;
    cpu_op(1'b0, 1'b0, 26'h180, 16'h0000, rd, er, rq, dn);
    vectors++; if (dn - rq != 4) begin miscompares++; $display("FAIL ml_latency got %0d want 4", dn - rq); end
    vectors++; if (rd !== 16'h0077) begin miscompares++; $display("FAIL ml_zero_extend got %h want 0077", rd); end
  endtask

  task automatic test_dummy_read();
    act_q.delete(); exp_q.delete();
    lo_delay = 0; hi_delay = 2;
    cpu_op(1'b1, 1'b0, 26'h300, 16'h0011, rd, er, rq, dn);
    cpu_op(1'b1, 1'b0, 26'h300, 16'h0022, rd, er, rq, dn);
    vectors++; if (mem[26'h300] !== 8'h22) begin miscompares++; $display("FAIL dr_mem got %h want 22", mem[26'h300]); end
    exp_q.push_back({1'b1, 26'h300, 8'h11});
    exp_q.push_back({1'b0, 26'h301, 8'h00});
    exp_q.push_back({1'b1, 26'h300, 8'h22});
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL dr_txn_count got %0d want %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_txn = exp_q.pop_front(); g_txn = act_q.pop_front(); vectors++;
      if (g_txn !== e_txn) begin miscompares++; $display("FAIL dr_txn got %h want %h", g_txn, e_txn); end
    end
  endtask

  task automatic test_wrap();
    act_q.delete(); exp_q.delete();
    lo_delay = 1; hi_delay = 1;
    cpu_op(1'b1, 1'b1, 26'h3FFFFFF, 16'hBEEF, rd, er, rq, dn);
    vectors++; if (mem[26'h3FFFFFF] !== 8'hEF) begin miscompares++; $display("FAIL wrap_lo got %h want ef", mem[26'h3FFFFFF]); end
    vectors++; if (mem[26'h0] !== 8'hBE) begin miscompares++; $display("FAIL wrap_hi got %h want be", mem[26'h0]); end
    exp_q.push_back({1'b1, 26'h3FFFFFF, 8'hEF});
    exp_q.push_back({1'b1, 26'h0000000, 8'hBE});
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL wrap_txn_count got %0d want %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_txn = exp_q.pop_front(); g_txn = act_q.pop_front(); vectors++;
      if (g_txn !== e_txn) begin miscompares++; $display("FAIL wrap_txn got %h want %h", g_txn, e_txn); end
    end
  endtask

  task automatic test_timeout();
    act_q.delete(); exp_q.delete();
    stuck = 1;
    cpu_op(1'b0, 1'b0, 26'h500, 16'h0000, rd, er, rq, dn);
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL to_err got %b want 1", er); end
    vectors++; if (dn != det_cyc + 16) begin miscompares++; $display("FAIL to_cycles got %0d want %0d", dn, det_cyc + 16); end
    @(negedge clock_100_mhz);
    vectors++; if (bus.cpu_err !== 1'b1) begin miscompares++; $display("FAIL to_err_held got %b want 1", bus.cpu_err); end
    stuck = 0; lo_delay = 0; hi_delay = 2;
    cpu_op(1'b1, 1'b0, 26'h600, 16'h0066, rd, er, rq, dn);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL to_err_cleared got %b want 0", er); end
    vectors++; if (mem[26'h600] !== 8'h66) begin miscompares++; $display("FAIL to_next_mem got %h want 66", mem[26'h600]); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    act_q.delete(); exp_q.delete();
    lo_delay = 0; hi_delay = 10;
    hit = 0;
    @(negedge clock_100_mhz);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_word = 1'b1;
    bus.cpu_address = 26'h800; bus.cpu_wdata = 16'hA55A;
    @(negedge clock_100_mhz);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_word = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (dbg_state === ST_WAIT_HI) hit = 1;
      else @(negedge clock_100_mhz);
    end
    vectors++; if (!hit) begin miscompares++; $display("FAIL rm_reach_wait_hi got state %0d want %0d", dbg_state, ST_WAIT_HI); end
    #2 reset_n = 1'b0;
    #1;
    vectors++; if (bus.cpu_busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy got %b want 0", bus.cpu_busy); end
    vectors++; if (bus.cpu_done !== 1'b0) begin miscompares++; $display("FAIL rm_done got %b want 0", bus.cpu_done); end
    vectors++; if (bus.cpu_err !== 1'b0) begin miscompares++; $display("FAIL rm_err got %b want 0", bus.cpu_err); end
    vectors++; if (bus.cpu_rdata !== 16'h0000) begin miscompares++; $display("FAIL rm_rdata got %h want 0000", bus.cpu_rdata); end
    vectors++; if (bus.m_address !== 26'h0) begin miscompares++; $display("FAIL rm_maddr got %h want 0", bus.m_address); end
    vectors++; if (bus.m_we !== 1'b0) begin miscompares++; $display("FAIL rm_mwe got %b want 0", bus.m_we); end
    vectors++; if (bus.m_wdata !== 8'h00) begin miscompares++; $display("FAIL rm_mwdata got %h want 00", bus.m_wdata); end
    vectors++; if (dbg_state !== ST_IDLE) begin miscompares++; $display("FAIL rm_state got %0d want %0d", dbg_state, ST_IDLE); end
    @(negedge clock_100_mhz);
    #1 reset_n = 1'b1;
    act_q.delete();
    lo_delay = 0; hi_delay = 1;
    cpu_op(1'b1, 1'b1, 26'h800, 16'hCAFE, rd, er, rq, dn);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL rm_after_err got %b want 0", er); end
    vectors++; if (mem[26'h800] !== 8'hFE) begin miscompares++; $display("FAIL rm_after_lo got %h want fe", mem[26'h800]); end
    vectors++; if (mem[26'h801] !== 8'hCA) begin miscompares++; $display("FAIL rm_after_hi got %h want ca", mem[26'h801]); end
    exp_q.push_back({1'b1, 26'h800, 8'hFE});
    exp_q.push_back({1'b1, 26'h801, 8'hCA});
    vectors++;
    if (act_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rm_txn_count got %0d want %0d", act_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && act_q.size() > 0) begin
      e_txn = exp_q.pop_front(); g_txn = act_q.pop_front(); vectors++;
      if (g_txn !== e_txn) begin miscompares++; $display("FAIL rm_txn got %h want %h", g_txn, e_txn); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.cpu_req     = 1'b0;
    bus.cpu_we      = 1'b0;
    bus.cpu_word    = 1'b0;
    bus.cpu_address = '0;
    bus.cpu_wdata   = '0;
    test_reset();
    test_byte_write();
    test_word_read();
    test_min_latency();
    test_dummy_read();
    test_wrap();
    test_timeout();
    test_reset_mid();
    repeat (2) @(negedge clock_100_mhz);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
